memory_read_arbiter: RTL and testbench
======================================

Name: memory_read_arbiter

Overview:
- Shares the single read port of one dual_port_ram bank between NUM_REQUESTERS PE read_port instances and the host mmio read path.
- Host reads have absolute priority. PE requesters are served round-robin, one RAM read per cycle.
- Each response is routed back to the requester that issued it, matched to the RAM's 1-cycle read latency.
- Sits between the read ports and the RAM inside multi-reader memory blocks, replacing per-reader bank duplication.

Parameters:
NUM_REQUESTERS, 4, number of PE-side read requesters (>= 2)
INDEX_WIDTH, 10, RAM index width ($clog2 of RAM depth)
WORD_WIDTH, 32, data word width (TIA_WORD_WIDTH)

Ports:
clock  input  1  positive-edge clock
reset  input  1  synchronous, active-high reset
enable  input  1  active-high; low blocks new issues
req_valid  input  NUM_REQUESTERS  requester i has a read pending
req_index  input  NUM_REQUESTERS*INDEX_WIDTH  packed indices; slice i belongs to requester i
req_ready  output  NUM_REQUESTERS  one-hot grant; request accepted this cycle
resp_ready  input  NUM_REQUESTERS  requester i can absorb a response next cycle
resp_valid  output  NUM_REQUESTERS  one-hot; resp_data belongs to requester i
resp_data  output  WORD_WIDTH  read data, shared by all requesters
host_read_req  input  1  host read request, held until ack
host_read_index  input  INDEX_WIDTH  host read address
host_read_ack  output  1  host data valid
host_read_data  output  WORD_WIDTH  host read data
ram_read_enable  output  1  RAM read strobe
ram_read_index  output  INDEX_WIDTH  RAM read address
ram_read_data  input  WORD_WIDTH  RAM data, valid 1 cycle after strobe
quiescent  output  1  no pending or in-flight reads (registered)

Behaviour:
- Reset values (synchronous): req_ready=0, resp_valid=0, host_read_ack=0, ram_read_enable=0, round-robin pointer=0, in-flight register empty, quiescent=0.
- Issue cycle (combinational, only when enable=1):
  - Host path: if host_read_req=1 and host_read_ack=0 and no host read is in flight, issue the host read. ram_read_enable=1, ram_read_index=host_read_index, all req_ready=0.
  - PE path otherwise: eligible(i) = req_valid[i] & resp_ready[i]. Grant the first eligible i searching from the pointer upward with wrap.
  - On a PE grant: req_ready[g]=1, ram_read_enable=1, ram_read_index=req_index slice g. Registered pointer becomes (g+1) mod NUM_REQUESTERS.
  - No grant means the pointer is unchanged.
- In-flight register: records owner (host or requester id) plus a valid bit, captured in the issue cycle.
- Response cycle (issue + 1):
  - PE owner g: resp_valid[g]=1 (registered), resp_data=ram_read_data (combinational pass-through).
  - Host owner: host_read_ack=1 (registered), host_read_data=ram_read_data.
  - host_read_data and resp_data are don't-care when not valid.
  - The response stage always completes, even if enable drops in between.
- Host handshake: host_read_ack is high for exactly one cycle per host read. The host drops req on ack. If req is still high the cycle after ack, a new read is issued (ack alternates 1/0 under continuous req).
- Throughput: one issue per cycle, pipelined. Issue and the previous response may overlap in the same cycle.
- Simultaneous host and PE requests: the host wins. PE requests wait, and the pointer is not advanced.
- resp_ready is sampled only in the issue cycle. A requester that lowers it after the grant still receives its response.
- enable=0: no issue, req_ready=0, pointer held, quiescent held.
- Reset mid-operation: the in-flight response is discarded. No resp_valid or ack follows the reset.
- quiescent: registered each enabled cycle as (no req_valid) & !host_read_req & in-flight empty.

Decomposition:
- Shared package memory_pkg: owner encoding typedef (host flag + requester id of $clog2(NUM_REQUESTERS) bits) and WORD_WIDTH from TIA_WORD_WIDTH.
- One sub-module: round_robin_arbiter. Inputs: eligible vector and pointer. Outputs: one-hot grant and grant id. Purely combinational and reusable elsewhere.

Test Plan:
- Single PE read: req_valid=0001, index 5, RAM[5]=0xAA → req_ready=0001 at t, resp_valid=0001 and resp_data=0xAA at t+1.
- All four requesters valid continuously for 8 cycles, pointer 0 → grants 0,1,2,3,0,1,2,3, one per cycle, each response tagged to the correct requester.
- Host read at index 9 while requesters 1 and 2 are valid → RAM reads 9 first, host_read_ack=1 at t+1 with RAM[9]. Then grants go 1, then 2; the pointer does not advance on the host cycle.
- resp_ready=0 for requester 0 with req_valid=0011 → only requester 1 is granted repeatedly. Raising resp_ready[0] yields a grant to 0 at the next turn.
- Host req held high 4 cycles → ack pattern 0,1,0,1. Reset asserted the cycle after an issue → no resp_valid or ack, and all outputs are at reset values.
- enable=0 with pending requests → no ram_read_enable and pointer unchanged. An in-flight read issued the previous cycle still returns resp_valid.

Source files
------------

// File: rtl/memory_pkg.sv
// Shared types for the memory block: word width and the in-flight read owner tag.
package memory_pkg;

  // Native datapath word width of the fabric.
  localparam int TIA_WORD_WIDTH = 32;

  // Width of the requester id field in an owner tag; covers up to 16 requesters.
  localparam int OWNER_ID_WIDTH = 4;

  // Owner of a RAM read: either the host, or PE requester 'id'.
  typedef struct packed {
    logic                      host;
    logic [OWNER_ID_WIDTH-1:0] id;
  } owner_t;

endpackage : memory_pkg

// File: rtl/round_robin_arbiter.sv
// Combinational round-robin pick: first eligible requester at or above the
// pointer, wrapping around to the lowest index when nothing above is eligible.
module round_robin_arbiter #(
  parameter int NUM_REQUESTERS = 4,
  parameter int ID_WIDTH       = $clog2(NUM_REQUESTERS)
) (
  input  logic [NUM_REQUESTERS-1:0] eligible,
  input  logic [ID_WIDTH-1:0]       pointer,
  output logic [NUM_REQUESTERS-1:0] grant,
  output logic [ID_WIDTH-1:0]       grant_id,
  output logic                      grant_valid
);

  logic [NUM_REQUESTERS-1:0] upper_mask_s;
  logic [NUM_REQUESTERS-1:0] upper_eligible_s;
  logic                      upper_found_s;

  // Search the requesters at or above the pointer first, then wrap to the bottom.
  always_comb begin
    grant            = '0;
    grant_id         = '0;
    grant_valid      = 1'b0;
    upper_mask_s     = '0;
    upper_found_s    = 1'b0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      upper_mask_s[i] = (ID_WIDTH'(i) >= pointer);
    end
    upper_eligible_s = eligible & upper_mask_s;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      if (!upper_found_s && upper_eligible_s[i]) begin
        grant[i]      = 1'b1;
        grant_id      = ID_WIDTH'(i);
        upper_found_s = 1'b1;
      end else begin
        upper_found_s = upper_found_s;
      end
    end
    grant_valid = upper_found_s;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      if (!grant_valid && eligible[i]) begin
        grant[i]    = 1'b1;
        grant_id    = ID_WIDTH'(i);
        grant_valid = 1'b1;
      end else begin
        grant_valid = grant_valid;
      end
    end
  end

endmodule : round_robin_arbiter

// File: rtl/memory_read_arbiter.sv
// Shares one RAM read port between the host mmio read path (absolute priority)
// and NUM_REQUESTERS PE read ports (round-robin), routing each 1-cycle-latency
// response back to the requester that issued it.
module memory_read_arbiter
  import memory_pkg::*;
#(
  parameter int NUM_REQUESTERS = 4,
  parameter int INDEX_WIDTH    = 10,
  parameter int WORD_WIDTH     = TIA_WORD_WIDTH
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                enable,
  input  logic [NUM_REQUESTERS-1:0]           req_valid,
  input  logic [NUM_REQUESTERS*INDEX_WIDTH-1:0] req_index,
  output logic [NUM_REQUESTERS-1:0]           req_ready,
  input  logic [NUM_REQUESTERS-1:0]           resp_ready,
  output logic [NUM_REQUESTERS-1:0]           resp_valid,
  output logic [WORD_WIDTH-1:0]               resp_data,
  input  logic                                host_read_req,
  input  logic [INDEX_WIDTH-1:0]              host_read_index,
  output logic                                host_read_ack,
  output logic [WORD_WIDTH-1:0]               host_read_data,
  output logic                                ram_read_enable,
  output logic [INDEX_WIDTH-1:0]              ram_read_index,
  input  logic [WORD_WIDTH-1:0]               ram_read_data,
  output logic                                quiescent
);

  localparam int ID_WIDTH = $clog2(NUM_REQUESTERS);

  logic [NUM_REQUESTERS-1:0] eligible_s;
  logic [NUM_REQUESTERS-1:0] grant_s;
  logic [ID_WIDTH-1:0]       grant_id_s;
  logic                      grant_valid_s;
  logic                      issue_allowed_s;
  logic                      host_busy_s;
  logic                      host_issue_s;
  logic                      pe_issue_s;
  logic [INDEX_WIDTH-1:0]    pe_index_s;
  logic [ID_WIDTH-1:0]       pointer_next_s;
  logic                      quiescent_next_s;
  owner_t                    issue_owner_s;

  logic [ID_WIDTH-1:0]       pointer_r;
  logic                      inflight_valid_r;
  owner_t                    inflight_owner_r;
  logic                      quiescent_r;

  round_robin_arbiter #(
    .NUM_REQUESTERS (NUM_REQUESTERS),
    .ID_WIDTH       (ID_WIDTH)
  ) u_round_robin_arbiter (
    .eligible    (eligible_s),
    .pointer     (pointer_r),
    .grant       (grant_s),
    .grant_id    (grant_id_s),
    .grant_valid (grant_valid_s)
  );

  // Issue stage: pick host or PE read, drive the RAM strobe and next pointer.
  always_comb begin
    eligible_s      = req_valid & resp_ready;
    issue_allowed_s = enable & ~reset;
    // A host read in flight is exactly the cycle its ack is shown; block re-issue then.
    host_busy_s     = inflight_valid_r & inflight_owner_r.host;
    host_issue_s    = issue_allowed_s & host_read_req & ~host_busy_s;
    pe_issue_s      = issue_allowed_s & ~host_issue_s & grant_valid_s;

    pe_index_s = '0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      if (grant_s[i]) begin
        pe_index_s = req_index[i*INDEX_WIDTH +: INDEX_WIDTH];
      end else begin
        pe_index_s = pe_index_s;
      end
    end

    ram_read_enable = host_issue_s | pe_issue_s;
    if (host_issue_s) begin
      ram_read_index = host_read_index;
    end else if (pe_issue_s) begin
      ram_read_index = pe_index_s;
    end else begin
      ram_read_index = '0;
    end

    if (pe_issue_s) begin
      req_ready = grant_s;
    end else begin
      req_ready = '0;
    end

    issue_owner_s.host = host_issue_s;
    if (host_issue_s) begin
      issue_owner_s.id = '0;
    end else begin
      issue_owner_s.id = OWNER_ID_WIDTH'(grant_id_s);
    end

    // The pointer moves only past an actual PE grant; host cycles leave it alone.
    if (pe_issue_s) begin
      if (grant_id_s == ID_WIDTH'(NUM_REQUESTERS - 1)) begin
        pointer_next_s = '0;
      end else begin
        pointer_next_s = grant_id_s + ID_WIDTH'(1);
      end
    end else begin
      pointer_next_s = pointer_r;
    end

    quiescent_next_s = ~(|req_valid) & ~host_read_req & ~inflight_valid_r;
  end

  // State: round-robin pointer, in-flight owner record and quiescent flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      pointer_r        <= '0;
      inflight_valid_r <= 1'b0;
      inflight_owner_r <= '0;
      quiescent_r      <= 1'b0;
    end else begin
      pointer_r        <= pointer_next_s;
      inflight_valid_r <= host_issue_s | pe_issue_s;
      inflight_owner_r <= issue_owner_s;
      if (enable) begin
        quiescent_r <= quiescent_next_s;
      end
    end
  end

  // Response stage: decode the in-flight owner; reset suppresses any pending response.
  always_comb begin
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      resp_valid[i] = inflight_valid_r & ~inflight_owner_r.host &
                      (inflight_owner_r.id == OWNER_ID_WIDTH'(i)) & ~reset;
    end
    host_read_ack  = inflight_valid_r & inflight_owner_r.host & ~reset;
    resp_data      = ram_read_data;
    host_read_data = ram_read_data;
    quiescent      = quiescent_r & ~reset;
  end

endmodule : memory_read_arbiter

// File: tb/tb_memory_read_arbiter.sv
// Bench for memory_read_arbiter: RAM model, scoreboard of expected responses
// and per-scenario tasks with directed expectations.
module tb_memory_read_arbiter;

  localparam int N  = 4;
  localparam int IW = 10;
  localparam int WW = 32;

  logic            clock = 1'b0;
  logic            reset;
  logic            enable;
  logic [N-1:0]    req_valid;
  logic [N*IW-1:0] req_index;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    resp_ready;
  logic [N-1:0]    resp_valid;
  logic [WW-1:0]   resp_data;
  logic            host_read_req;
  logic [IW-1:0]   host_read_index;
  logic            host_read_ack;
  logic [WW-1:0]   host_read_data;
  logic            ram_read_enable;
  logic [IW-1:0]   ram_read_index;
  logic [WW-1:0]   ram_read_data = 32'h0;
  logic            quiescent;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [WW-1:0] mem [1024];

  typedef struct {
    int          due;
    bit          host;
    int          id;
    logic [31:0] data;
  } exp_t;
  exp_t sbq [$];

  // Model state
  int m_ptr        = 0;
  bit m_prev_host  = 1'b0;
  bit m_prev_issue = 1'b0;
  bit m_q          = 1'b0;

  memory_read_arbiter #(
    .NUM_REQUESTERS (N),
    .INDEX_WIDTH    (IW),
    .WORD_WIDTH     (WW)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .enable          (enable),
    .req_valid       (req_valid),
    .req_index       (req_index),
    .req_ready       (req_ready),
    .resp_ready      (resp_ready),
    .resp_valid      (resp_valid),
    .resp_data       (resp_data),
    .host_read_req   (host_read_req),
    .host_read_index (host_read_index),
    .host_read_ack   (host_read_ack),
    .host_read_data  (host_read_data),
    .ram_read_enable (ram_read_enable),
    .ram_read_index  (ram_read_index),
    .ram_read_data   (ram_read_data),
    .quiescent       (quiescent)
  );

  always #5 clock = ~clock;

  // One-cycle-latency RAM
  always @(posedge clock) begin
    if (ram_read_enable) ram_read_data <= mem[ram_read_index];
  end

  always @(posedge clock) cyc <= cyc + 1;

  function automatic int model_pick(input logic [N-1:0] elig, input int ptr);
    for (int k = 0; k < N; k++) begin
      int c = (ptr + k) % N;
      if (elig[c]) return c;
    end
    return -1;
  endfunction

  // Scoreboard monitor: predicts each issue, queues the response, checks it next cycle.
  always @(negedge clock) begin
    exp_t          e;
    logic [N-1:0]  exp_ready;
    logic [N-1:0]  exp_rv;
    logic [IW-1:0] exp_idx;
    logic [WW-1:0] act_data;
    bit            exp_en;
    bit            hi;
    bit            pe;
    int            g;
    if (reset) begin
      checks++;
      if (req_ready !== 4'b0 || resp_valid !== 4'b0 || host_read_ack !== 1'b0 ||
          ram_read_enable !== 1'b0 || quiescent !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs cyc=%0d: req_ready=%b resp_valid=%b ack=%b ram_en=%b q=%b, want all 0",
                 cyc, req_ready, resp_valid, host_read_ack, ram_read_enable, quiescent);
      end
      sbq.delete();
      m_ptr = 0; m_prev_host = 1'b0; m_prev_issue = 1'b0; m_q = 1'b0;
    end else begin
      checks++;
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
        e = sbq.pop_front();
        exp_rv   = e.host ? 4'b0 : 4'(1 << e.id);
        act_data = e.host ? host_read_data : resp_data;
        if (resp_valid !== exp_rv || host_read_ack !== e.host || act_data !== e.data) begin
          errors++;
          $display("FAIL sb_response cyc=%0d: resp_valid=%b ack=%b data=%h, want resp_valid=%b ack=%b data=%h",
                   cyc, resp_valid, host_read_ack, act_data, exp_rv, e.host, e.data);
        end
      end else begin
        if (resp_valid !== 4'b0 || host_read_ack !== 1'b0) begin
          errors++;
          $display("FAIL sb_idle_response cyc=%0d: resp_valid=%b ack=%b, want 0000 0",
                   cyc, resp_valid, host_read_ack);
        end
      end
      checks++;
      if (quiescent !== m_q) begin
        errors++;
        $display("FAIL sb_quiescent cyc=%0d: got %b want %b", cyc, quiescent, m_q);
      end
      hi = enable && host_read_req && !m_prev_host;
      g  = model_pick(req_valid & resp_ready, m_ptr);
      pe = enable && !hi && (g >= 0);
      exp_ready = pe ? 4'(1 << g) : 4'b0;
      exp_en    = hi || pe;
      exp_idx   = hi ? host_read_index : (pe ? 10'(req_index >> (g * IW)) : 10'd0);
      checks++;
      if (req_ready !== exp_ready || ram_read_enable !== exp_en ||
          (exp_en && ram_read_index !== exp_idx)) begin
        errors++;
        $display("FAIL sb_issue cyc=%0d: req_ready=%b ram_en=%b idx=%0d, want %b %b %0d",
                 cyc, req_ready, ram_read_enable, ram_read_index, exp_ready, exp_en, exp_idx);
      end
      if (exp_en) begin
        e.due = cyc + 1; e.host = hi; e.id = g; e.data = mem[exp_idx];
        sbq.push_back(e);
      end
      if (enable) m_q = (req_valid == 4'b0) && !host_read_req && !m_prev_issue;
      m_prev_host  = hi;
      m_prev_issue = exp_en;
      if (pe) m_ptr = (g + 1) % N;
    end
  end

  task automatic tick;
    @(posedge clock); #1;
  endtask

  task automatic settle;
    @(negedge clock); #1;
  endtask

  task automatic test_reset;
    settle;
    checks++;
    if (req_ready !== 4'b0 || ram_read_enable !== 1'b0 || quiescent !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: req_ready=%b ram_en=%b q=%b, want 0", req_ready, ram_read_enable, quiescent);
    end
    tick;
    reset = 1'b0; enable = 1'b1; resp_ready = 4'hF;
    settle;
    checks++;
    if (quiescent !== 1'b0) begin
      errors++;
      $display("FAIL reset_quiescent_first: got %b want 0", quiescent);
    end
    tick;
    settle;
    checks++;
    if (quiescent !== 1'b1) begin
      errors++;
      $display("FAIL idle_quiescent: got %b want 1", quiescent);
    end
  endtask

  task automatic test_single_read;
    tick;
    req_index = {10'd0, 10'd0, 10'd0, 10'd5};
    req_valid = 4'b0001;
    settle;
    checks++;
    if (req_ready !== 4'b0001 || ram_read_index !== 10'd5) begin
      errors++;
      $display("FAIL single_issue: req_ready=%b idx=%0d, want 0001 5", req_ready, ram_read_index);
    end
    tick;
    req_valid = 4'b0000;
    settle;
    checks++;
    if (resp_valid !== 4'b0001 || resp_data !== 32'hAA) begin
      errors++;
      $display("FAIL single_response: resp_valid=%b data=%h, want 0001 000000aa", resp_valid, resp_data);
    end
  endtask

  task automatic test_round_robin;
    tick; reset = 1'b1;
    tick; reset = 1'b0;
    req_valid = 4'hF;
    req_index = {10'd40, 10'd30, 10'd20, 10'd10};
    for (int k = 0; k < 8; k++) begin
      settle;
      checks++;
      if (req_ready !== 4'(1 << (k % 4))) begin
        errors++;
        $display("FAIL rr_grant k=%0d: got %b want %b", k, req_ready, 4'(1 << (k % 4)));
      end
      tick;
    end
    req_valid = 4'b0;
    settle;
    checks++;
    if (resp_valid !== 4'b1000 || resp_data !== mem[40]) begin
      errors++;
      $display("FAIL rr_last_response: resp_valid=%b data=%h, want 1000 %h", resp_valid, resp_data, mem[40]);
    end
  endtask

  task automatic test_host_priority;
    tick;
    req_valid = 4'b0110;
    req_index = {10'd44, 10'd22, 10'd11, 10'd1};
    host_read_req = 1'b1; host_read_index = 10'd9;
    settle;
    checks++;
    if (ram_read_enable !== 1'b1 || ram_read_index !== 10'd9 || req_ready !== 4'b0) begin
      errors++;
      $display("FAIL host_first: ram_en=%b idx=%0d req_ready=%b, want 1 9 0000",
               ram_read_enable, ram_read_index, req_ready);
    end
    tick;
    settle;
    checks++;
    if (host_read_ack !== 1'b1 || host_read_data !== mem[9] || req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL host_ack: ack=%b data=%h req_ready=%b, want 1 %h 0010",
               host_read_ack, host_read_data, req_ready, mem[9]);
    end
    tick;
    host_read_req = 1'b0;
    settle;
    checks++;
    if (req_ready !== 4'b0100 || ram_read_index !== 10'd22) begin
      errors++;
      $display("FAIL host_then_pe2: req_ready=%b idx=%0d, want 0100 22", req_ready, ram_read_index);
    end
    tick;
    req_valid = 4'b0;
  endtask

  task automatic test_resp_ready_block;
    req_valid = 4'b0011; resp_ready = 4'b1110;
    for (int k = 0; k < 3; k++) begin
      settle;
      checks++;
      if (req_ready !== 4'b0010) begin
        errors++;
        $display("FAIL blocked_grant k=%0d: got %b want 0010", k, req_ready);
      end
      tick;
    end
    resp_ready = 4'hF;
    settle;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL unblocked_grant0: got %b want 0001", req_ready);
    end
    tick;
    settle;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL unblocked_grant1: got %b want 0010", req_ready);
    end
    tick;
    req_valid = 4'b0;
  endtask

  task automatic test_host_stream;
    host_read_req = 1'b1; host_read_index = 10'd3;
    for (int k = 0; k < 4; k++) begin
      settle;
      checks++;
      if (host_read_ack !== 1'((k % 2)) || ((k % 2) == 1 && host_read_data !== mem[3])) begin
        errors++;
        $display("FAIL host_stream k=%0d: ack=%b data=%h, want ack=%0d data=%h",
                 k, host_read_ack, host_read_data, k % 2, mem[3]);
      end
      tick;
    end
    host_read_req = 1'b0;
    settle;
    checks++;
    if (host_read_ack !== 1'b0) begin
      errors++;
      $display("FAIL host_stream_end: ack=%b want 0", host_read_ack);
    end
  endtask

  task automatic test_reset_midflight;
    tick;
    req_valid = 4'b0001; req_index = {30'd0, 10'd7};
    settle;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL midflight_issue: got %b want 0001", req_ready);
    end
    tick;
    reset = 1'b1; req_valid = 4'b0;
    settle;
    checks++;
    if (resp_valid !== 4'b0 || host_read_ack !== 1'b0 || ram_read_enable !== 1'b0) begin
      errors++;
      $display("FAIL midflight_reset: resp_valid=%b ack=%b ram_en=%b, want 0",
               resp_valid, host_read_ack, ram_read_enable);
    end
    tick;
    reset = 1'b0;
    settle;
    checks++;
    if (resp_valid !== 4'b0 || host_read_ack !== 1'b0) begin
      errors++;
      $display("FAIL midflight_after: resp_valid=%b ack=%b, want 0", resp_valid, host_read_ack);
    end
  endtask

  task automatic test_enable_low;
    tick;
    req_valid = 4'b0100; req_index = {10'd0, 10'd33, 10'd0, 10'd0};
    settle;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL en_pre_grant: got %b want 0100", req_ready);
    end
    tick;
    enable = 1'b0; req_valid = 4'hF;
    settle;
    checks++;
    if (ram_read_enable !== 1'b0 || req_ready !== 4'b0 || resp_valid !== 4'b0100 || resp_data !== mem[33]) begin
      errors++;
      $display("FAIL en_low_inflight: ram_en=%b req_ready=%b resp_valid=%b data=%h, want 0 0000 0100 %h",
               ram_read_enable, req_ready, resp_valid, resp_data, mem[33]);
    end
    tick;
    settle;
    checks++;
    if (ram_read_enable !== 1'b0 || resp_valid !== 4'b0) begin
      errors++;
      $display("FAIL en_low_idle: ram_en=%b resp_valid=%b, want 0 0000", ram_read_enable, resp_valid);
    end
    tick;
    enable = 1'b1;
    settle;
    checks++;
    if (req_ready !== 4'b1000) begin
      errors++;
      $display("FAIL en_pointer_held: got %b want 1000", req_ready);
    end
    tick;
    req_valid = 4'b0;
    tick;
    tick;
    settle;
    checks++;
    if (quiescent !== 1'b1) begin
      errors++;
      $display("FAIL end_quiescent: got %b want 1", quiescent);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'(i) * 32'h0000_9E37 + 32'h1000_0000;
    mem[5] = 32'h0000_00AA;
    reset = 1'b1; enable = 1'b0;
    req_valid = 4'b0; req_index = '0; resp_ready = 4'b0;
    host_read_req = 1'b0; host_read_index = 10'd0;

    test_reset;
    test_single_read;
    test_round_robin;
    test_host_priority;
    test_resp_ready_block;
    test_host_stream;
    test_reset_midflight;
    test_enable_low;

    tick; tick;
    settle;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses never observed, want 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_memory_read_arbiter
